// File: rtl/uart_print_arbiter.sv
// Message-granular round-robin arbiter: locks one print source onto the UART
// transmitter for a whole message (or until the burst cap), then rotates.
module uart_print_arbiter #(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_reg, state_next;
   logic [N_REQ-1:0] grant_reg, grant_next;
   logic [PW-1:0]    rr_ptr_reg, rr_ptr_next;
   logic [BW-1:0]    burst_cnt_reg, burst_cnt_next;

   logic [PW-1:0]    owner_idx;
   logic [PW-1:0]    pick_idx;
   logic             pick_found;
   logic [PW:0]      scan_idx;
   logic             xfer;
   logic             owner_last;
   logic             cap_hit;
   logic [7:0]       data_masked [N_REQ];
   logic [N_REQ-1:0] ready_vec;

   // Per-requester gating; the data mux is an OR of masked lanes since grant is one-hot.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
         assign data_masked[gi] = grant_reg[gi] ? req_data[8*gi +: 8] : 8'h00;
         assign ready_vec[gi]   = grant_reg[gi] & tx_ready;
      end
   endgenerate

   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_reg[i]) owner_idx = PW'(i);
      end
   end

   // Rotating scan starting just after the last owner.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = rr_ptr_reg;
      scan_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr_reg} + (PW+1)'(k);
         if (scan_idx >= (PW+1)'(N_REQ)) scan_idx = scan_idx - (PW+1)'(N_REQ);
         if (!pick_found && req_valid[scan_idx[PW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx[PW-1:0];
         end
      end
   end

   assign xfer       = tx_valid & tx_ready;
   assign owner_last = |(grant_reg & req_last);
   assign cap_hit    = (MAX_BURST != 0) && (burst_cnt_reg == BW'(MAX_BURST - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         grant_reg     <= '0;
         rr_ptr_reg    <= PW'(N_REQ - 1);
         burst_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         rr_ptr_reg    <= rr_ptr_next;
         burst_cnt_reg <= burst_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      grant_next     = grant_reg;
      rr_ptr_next    = rr_ptr_reg;
      burst_cnt_next = burst_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               state_next     = GRANT;
               grant_next     = N_REQ'(1) << pick_idx;
               burst_cnt_next = '0;
            end
         end
         GRANT: begin
            if (xfer) begin
               burst_cnt_next = burst_cnt_reg + BW'(1);
               if (owner_last || cap_hit) begin
                  state_next  = IDLE;
                  grant_next  = '0;
                  rr_ptr_next = owner_idx;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Pass-through outputs derive from grant_reg so an async reset clears them at once.
   always_comb begin
      busy      = (state_reg == GRANT);
      grant     = grant_reg;
      tx_valid  = |(grant_reg & req_valid);
      req_ready = ready_vec;
      tx_data   = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         tx_data = tx_data | data_masked[i];
      end
   end

endmodule

// File: tb/tb_uart_print_arbiter.sv
// Scoreboard bench for uart_print_arbiter: queued requester model, expected
// byte order pushed per scenario and popped on every observed transfer.
module tb_uart_print_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        use_cap = 1'b0;
   logic        rst_main, rst_cap;
   logic [31:0] req_data = '0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_last = '0;
   logic        tx_ready = 1'b0;

   logic [3:0]  m_req_ready, c_req_ready, m_grant, c_grant;
   logic [7:0]  m_tx_data, c_tx_data;
   logic        m_tx_valid, c_tx_valid, m_busy, c_busy;

   logic [3:0]  o_req_ready, o_grant;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid, o_busy;

   logic [8:0]  src_q [4][$];
   logic [10:0] exp_q [$];
   int          xfer_cyc [$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          bp_mode = 1'b0;

   logic [3:0]  s_grant;
   logic [7:0]  s_tx_data;
   logic        s_busy, s_tx_valid, s_xfer;

   assign rst_main = rst | use_cap;
   assign rst_cap  = rst | ~use_cap;

   uart_print_arbiter #(.N_REQ(4), .MAX_BURST(64)) dut (
      .clk(clk), .rst(rst_main), .req_data(req_data), .req_valid(req_valid),
      .req_last(req_last), .req_ready(m_req_ready), .tx_data(m_tx_data),
      .tx_valid(m_tx_valid), .tx_ready(tx_ready), .grant(m_grant), .busy(m_busy));

   uart_print_arbiter #(.N_REQ(4), .MAX_BURST(4)) dut_cap (
      .clk(clk), .rst(rst_cap), .req_data(req_data), .req_valid(req_valid),
      .req_last(req_last), .req_ready(c_req_ready), .tx_data(c_tx_data),
      .tx_valid(c_tx_valid), .tx_ready(tx_ready), .grant(c_grant), .busy(c_busy));

   assign o_req_ready = use_cap ? c_req_ready : m_req_ready;
   assign o_grant     = use_cap ? c_grant     : m_grant;
   assign o_tx_data   = use_cap ? c_tx_data   : m_tx_data;
   assign o_tx_valid  = use_cap ? c_tx_valid  : m_tx_valid;
   assign o_busy      = use_cap ? c_busy      : m_busy;

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         if (src_q[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = src_q[i][0][7:0];
            req_last[i]        = src_q[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
      tx_ready = bp_mode ? ((cyc % 10) == 9) : 1'b1;
   endtask

   task automatic push_src(input int r, input int base, input int len);
      for (int k = 0; k < len; k++)
         src_q[r].push_back({(k == len - 1), 8'(base + k)});
   endtask

   task automatic expect_bytes(input int r, input int base, input int count);
      for (int k = 0; k < count; k++)
         exp_q.push_back({3'(r), 8'(base + k)});
   endtask

   task automatic clear_all();
      for (int i = 0; i < 4; i++) src_q[i].delete();
      exp_q.delete();
      xfer_cyc.delete();
   endtask

   // One clock: observe at the falling edge, advance requesters after the rising edge.
   task automatic step();
      logic [3:0]  hs;
      logic [10:0] e;
      int          owner;
      @(negedge clk);
      s_grant    = o_grant;
      s_busy     = o_busy;
      s_tx_valid = o_tx_valid;
      s_tx_data  = o_tx_data;
      s_xfer     = o_tx_valid & tx_ready;
      hs         = req_valid & o_req_ready;
      if (s_xfer) begin
         owner = 7;
         for (int i = 3; i >= 0; i--) if (s_grant[i]) owner = i;
         xfer_cyc.push_back(cyc);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL xfer: got req%0d 0x%02h, expected no transfer", owner, s_tx_data);
         end else begin
            e = exp_q.pop_front();
            if ({3'(owner), s_tx_data} !== e) begin
               n_fail++;
               $display("FAIL xfer: got req%0d 0x%02h, expected req%0d 0x%02h",
                        owner, s_tx_data, e[10:8], e[7:0]);
            end else begin
               $display("xfer cyc %0d: req%0d 0x%02h", cyc, owner, s_tx_data);
            end
         end
         n_checks++;
         if (o_req_ready !== s_grant) begin
            n_fail++;
            $display("FAIL req_ready: got %b, expected %b", o_req_ready, s_grant);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 4; i++)
         if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive();
   endtask

   task automatic run_until_drained(input int bound, input string tag);
      for (int k = 0; k < bound && exp_q.size() > 0; k++) step();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s drain: got %0d bytes outstanding, expected 0", tag, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 4'hF;
      req_last  = 4'hF;
      req_data  = 32'hA5A5_A5A5;
      tx_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks += 5;
      if (o_grant !== 4'b0)     begin n_fail++; $display("FAIL reset grant: got %b, expected 0000", o_grant); end
      if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL reset busy: got %b, expected 0", o_busy); end
      if (o_tx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset tx_valid: got %b, expected 0", o_tx_valid); end
      if (o_req_ready !== 4'b0) begin n_fail++; $display("FAIL reset req_ready: got %b, expected 0000", o_req_ready); end
      if (o_tx_data !== 8'h00)  begin n_fail++; $display("FAIL reset tx_data: got 0x%02h, expected 0x00", o_tx_data); end
      $display("reset: outputs idle");
      clear_all();
      drive();
      rst = 1'b0;
   endtask

   task automatic test_simultaneous();
      clear_all();
      push_src(0, 8'hA0, 2);
      push_src(2, 8'hC0, 2);
      expect_bytes(0, 8'hA0, 2);
      expect_bytes(2, 8'hC0, 2);
      drive();
      run_until_drained(20, "simultaneous");
      n_checks++;
      if (xfer_cyc.size() != 4) begin
         n_fail++;
         $display("FAIL simultaneous count: got %0d, expected 4", xfer_cyc.size());
      end else begin
         n_checks += 3;
         if (xfer_cyc[1] - xfer_cyc[0] != 1) begin n_fail++; $display("FAIL sim gap0: got %0d, expected 1", xfer_cyc[1] - xfer_cyc[0]); end
         if (xfer_cyc[2] - xfer_cyc[1] != 2) begin n_fail++; $display("FAIL sim bubble: got %0d, expected 2", xfer_cyc[2] - xfer_cyc[1]); end
         if (xfer_cyc[3] - xfer_cyc[2] != 1) begin n_fail++; $display("FAIL sim gap2: got %0d, expected 1", xfer_cyc[3] - xfer_cyc[2]); end
      end
      step();
   endtask

   task automatic test_single();
      int gcnt;
      clear_all();
      src_q[1].push_back({1'b0, 8'h48});
      src_q[1].push_back({1'b0, 8'h69});
      src_q[1].push_back({1'b1, 8'h0A});
      exp_q.push_back({3'd1, 8'h48});
      exp_q.push_back({3'd1, 8'h69});
      exp_q.push_back({3'd1, 8'h0A});
      drive();
      gcnt = 0;
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
         step();
         if (s_grant == 4'b0010) gcnt++;
      end
      step();
      if (s_grant == 4'b0010) gcnt++;
      n_checks += 4;
      if (gcnt != 3) begin n_fail++; $display("FAIL single grant cycles: got %0d, expected 3", gcnt); end
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL single drain: got %0d left, expected 0", exp_q.size()); end
      if (s_busy !== 1'b0 || s_grant !== 4'b0) begin
         n_fail++; $display("FAIL single idle: got busy %b grant %b, expected 0 0000", s_busy, s_grant);
      end
      if (xfer_cyc.size() != 3 || xfer_cyc[2] - xfer_cyc[0] != 2) begin
         n_fail++; $display("FAIL single consecutive: got %0d transfers, expected 3 back-to-back", xfer_cyc.size());
      end
      // rr_ptr is now 1, so requester 2 outranks requester 1.
      clear_all();
      push_src(1, 8'h11, 1);
      push_src(2, 8'h22, 1);
      expect_bytes(2, 8'h22, 1);
      expect_bytes(1, 8'h11, 1);
      drive();
      run_until_drained(20, "rr_after_single");
      step();
   endtask

   task automatic test_fairness();
      @(posedge clk); #1 rst = 1'b1;
      clear_all();
      drive();
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int m = 0; m < 3; m++) src_q[i].push_back({1'b1, 8'(16*i + m)});
      for (int m = 0; m < 3; m++)
         for (int i = 0; i < 4; i++) exp_q.push_back({3'(i), 8'(16*i + m)});
      drive();
      run_until_drained(60, "fairness");
      n_checks++;
      if (xfer_cyc.size() != 12) begin
         n_fail++; $display("FAIL fairness count: got %0d, expected 12", xfer_cyc.size());
      end
      for (int i = 1; i < xfer_cyc.size(); i++) begin
         n_checks++;
         if (xfer_cyc[i] - xfer_cyc[i-1] != 2) begin
            n_fail++;
            $display("FAIL fairness spacing %0d: got %0d, expected 2", i, xfer_cyc[i] - xfer_cyc[i-1]);
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      logic [7:0] prev_data;
      logic       prev_valid, prev_xfer, seen;
      int         drops, steps;
      clear_all();
      bp_mode = 1'b1;
      push_src(2, 8'h70, 5);
      expect_bytes(2, 8'h70, 5);
      drive();
      prev_valid = 1'b0; prev_xfer = 1'b0; prev_data = 8'h00;
      seen = 1'b0; drops = 0; steps = 0;
      for (int k = 0; k < 80 && exp_q.size() > 0; k++) begin
         step();
         steps++;
         if (prev_valid && !prev_xfer) begin
            n_checks++;
            if (!s_tx_valid || s_tx_data !== prev_data) begin
               n_fail++;
               $display("FAIL bp hold: got valid %b data 0x%02h, expected 1 0x%02h", s_tx_valid, s_tx_data, prev_data);
            end
         end
         if (s_busy) seen = 1'b1;
         else if (seen && exp_q.size() > 0) drops++;
         prev_valid = s_tx_valid; prev_xfer = s_xfer; prev_data = s_tx_data;
      end
      n_checks += 3;
      if (xfer_cyc.size() != 5) begin n_fail++; $display("FAIL bp count: got %0d, expected 5", xfer_cyc.size()); end
      if (drops != 0) begin n_fail++; $display("FAIL bp grant held: got %0d idle cycles, expected 0", drops); end
      if (steps > 55) begin n_fail++; $display("FAIL bp duration: got %0d cycles, expected <= 55", steps); end
      bp_mode = 1'b0;
      drive();
      step();
   endtask

   task automatic test_burst_cap();
      clear_all();
      use_cap = 1'b1;
      push_src(3, 8'h30, 10);
      expect_bytes(3, 8'h30, 4);
      expect_bytes(0, 8'h50, 2);
      expect_bytes(3, 8'h34, 4);
      expect_bytes(3, 8'h38, 2);
      drive();
      step();
      push_src(0, 8'h50, 2);
      drive();
      run_until_drained(60, "burst_cap");
      n_checks++;
      if (xfer_cyc.size() != 12) begin
         n_fail++; $display("FAIL cap count: got %0d, expected 12", xfer_cyc.size());
      end else begin
         n_checks += 2;
         if (xfer_cyc[4] - xfer_cyc[3] != 2) begin n_fail++; $display("FAIL cap release gap: got %0d, expected 2", xfer_cyc[4] - xfer_cyc[3]); end
         if (xfer_cyc[10] - xfer_cyc[9] != 2) begin n_fail++; $display("FAIL cap second release gap: got %0d, expected 2", xfer_cyc[10] - xfer_cyc[9]); end
      end
      step();
      use_cap = 1'b0;
      clear_all();
      drive();
      step();
   endtask

   task automatic test_reset_mid();
      clear_all();
      push_src(0, 8'hD0, 6);
      expect_bytes(0, 8'hD0, 6);
      drive();
      for (int k = 0; k < 20 && xfer_cyc.size() < 2; k++) step();
      n_checks++;
      if (o_tx_valid !== 1'b1 || o_grant !== 4'b0001) begin
         n_fail++; $display("FAIL mid pre-reset: got valid %b grant %b, expected 1 0001", o_tx_valid, o_grant);
      end
      #2 rst = 1'b1;
      #1;
      n_checks += 4;
      if (o_grant !== 4'b0)     begin n_fail++; $display("FAIL mid grant: got %b, expected 0000", o_grant); end
      if (o_tx_valid !== 1'b0)  begin n_fail++; $display("FAIL mid tx_valid: got %b, expected 0", o_tx_valid); end
      if (o_req_ready !== 4'b0) begin n_fail++; $display("FAIL mid req_ready: got %b, expected 0000", o_req_ready); end
      if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL mid busy: got %b, expected 0", o_busy); end
      $display("reset mid-message: outputs dropped");
      clear_all();
      drive();
      step();
      step();
      rst = 1'b0;
      push_src(3, 8'hE3, 1);
      push_src(0, 8'hE0, 1);
      expect_bytes(0, 8'hE0, 1);
      expect_bytes(3, 8'hE3, 1);
      drive();
      run_until_drained(20, "after_reset");
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_single();
      test_fairness();
      test_backpressure();
      test_burst_cap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
